// File: rtl/scoreboard_hzd.sv
// Register scoreboard: tracks outstanding writes and raises RAW/WAW issue stalls.
// Latency: stall/issue_ok combinational; pend state, pending_cnt, stall_count, wb_err update one edge later.
// Backpressure: stall holds the issuing instruction until its sources are ready and its destination is free.
module scoreboard_hzd #(
  parameter int REGW   = 5,
  parameter int LATW   = 4,
  parameter int BYPASS = 1,
  parameter int PERFW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iss_valid,
  input  logic [REGW-1:0]  iss_rs,
  input  logic             iss_rs_use,
  input  logic [REGW-1:0]  iss_rt,
  input  logic             iss_rt_use,
  input  logic [REGW-1:0]  iss_rd,
  input  logic             iss_rd_we,
  input  logic [LATW-1:0]  iss_lat,
  input  logic             wb_valid,
  input  logic [REGW-1:0]  wb_reg,
  input  logic             flush,
  output logic             stall,
  output logic             issue_ok,
  output logic [REGW:0]    pending_cnt,
  output logic [PERFW-1:0] stall_count,
  output logic             wb_err
);

  localparam int NREGS = 2 ** REGW;

  // Per-register scoreboard state
  logic [NREGS-1:0] pend_q, pend_d;
  logic [NREGS-1:0] var_q, var_d;
  logic [LATW-1:0]  cnt_q [NREGS];
  logic [LATW-1:0]  cnt_d [NREGS];

  // Registered outputs
  logic [REGW:0]    pcnt_q, pcnt_d;
  logic [PERFW-1:0] sc_q, sc_d;
  logic             werr_q, werr_d;

  // Hazard terms
  logic [NREGS-1:0] ready;
  logic             raw, waw, alloc;

  // A register is readable if nothing is pending, or (with forwarding) its producer completes this cycle
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      ready[r] = !pend_q[r]
              || (r == 0)
              || ((BYPASS != 0) && !var_q[r] && (cnt_q[r] == LATW'(1)))
              || ((BYPASS != 0) && var_q[r] && wb_valid && (wb_reg == REGW'(r)));
    end
  end

  // RAW/WAW detection and the issue handshake; a pending destination always stalls regardless of forwarding
  always_comb begin
    raw      = (iss_rs_use && !ready[iss_rs]) || (iss_rt_use && !ready[iss_rt]);
    waw      = iss_rd_we && (iss_rd != '0) && pend_q[iss_rd];
    stall    = iss_valid && (raw || waw) && !reset;
    issue_ok = iss_valid && !stall && !flush && !reset;
    alloc    = issue_ok && iss_rd_we && (iss_rd != '0);
  end

  // Next-state per entry: countdown/flush of fixed entries, writeback release of var entries, then allocation
  always_comb begin
    pend_d = pend_q;
    var_d  = var_q;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (pend_q[r] && !var_q[r]) begin
        // fixed entries are cancelled by flush; var entries survive since the unit cannot be stopped
        if (flush || (cnt_q[r] == LATW'(1))) begin
          pend_d[r] = 1'b0;
          cnt_d[r]  = '0;
        end else begin
          cnt_d[r] = cnt_q[r] - LATW'(1);
        end
      end
      if (pend_q[r] && var_q[r] && wb_valid && (wb_reg == REGW'(r))) begin
        pend_d[r] = 1'b0;
        var_d[r]  = 1'b0;
      end
      // WAW stall guarantees the allocated register is not being released in the same cycle
      if (alloc && (iss_rd == REGW'(r))) begin
        pend_d[r] = 1'b1;
        var_d[r]  = (iss_lat == '0);
        cnt_d[r]  = iss_lat;
      end
    end
  end

  // Writeback sanity: completing a register that has no outstanding variable-latency write is an error
  always_comb begin
    werr_d = wb_valid && ((wb_reg == '0) || !pend_q[wb_reg] || !var_q[wb_reg]);
  end

  // Occupancy is the population count of the post-update pending vector; stall counter saturates
  always_comb begin
    pcnt_d = '0;
    for (int r = 0; r < NREGS; r++) begin
      pcnt_d = pcnt_d + (REGW + 1)'(pend_d[r]);
    end
    sc_d = sc_q;
    if (stall && (sc_q != '1)) begin
      sc_d = sc_q + PERFW'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      var_q  <= '0;
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= '0;
      end
      pcnt_q <= '0;
      sc_q   <= '0;
      werr_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      var_q  <= var_d;
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      pcnt_q <= pcnt_d;
      sc_q   <= sc_d;
      werr_q <= werr_d;
    end
  end

  assign pending_cnt = pcnt_q;
  assign stall_count = sc_q;
  assign wb_err      = werr_q;

endmodule

// File: doc/scoreboard_hzd.md
Name: scoreboard_hzd

Overview:
- Parametrised successor to the single load-use hazard detector.
- Tracks every architectural register with an outstanding write, from issue (ID/EX boundary) until completion. Two kinds of write:
  - Fixed latency: ALU, multiplier.
  - Variable latency: loads that miss, divider. These complete on an explicit writeback strobe.
- Raises a stall for RAW and WAW hazards and supports an optional bypass mode.
- Supports a pipeline flush and provides occupancy and performance counters.

Parameters:
- REGW, 5: register index width; NREGS = 2**REGW entries.
- LATW, 4: latency field width; maximum fixed latency is 2**LATW-1.
- BYPASS, 1: 1 means a producer completing this cycle satisfies a consumer (forward path exists); 0 means the consumer waits one more cycle.
- PERFW, 16: width of the stall performance counter.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- iss_valid, input, 1: instruction presented for issue.
- iss_rs, input, REGW: source register A.
- iss_rs_use, input, 1: source A is read.
- iss_rt, input, REGW: source register B.
- iss_rt_use, input, 1: source B is read.
- iss_rd, input, REGW: destination register.
- iss_rd_we, input, 1: instruction writes iss_rd.
- iss_lat, input, LATW: write latency in cycles; 0 means variable (released by writeback).
- wb_valid, input, 1: variable-latency write completes this cycle.
- wb_reg, input, REGW: register completed by wb_valid.
- flush, input, 1: pipeline flush.
- stall, output, 1: combinational; holds the issuing instruction.
- issue_ok, output, 1: combinational; iss_valid && !stall && !flush.
- pending_cnt, output, REGW+1: registered; number of pending entries.
- stall_count, output, PERFW: registered; saturating count of cycles with stall=1.
- wb_err, output, 1: registered; one-cycle pulse on a spurious writeback.

Behaviour:
- Per-entry state:
  - pend: pending bit.
  - var: variable-latency flag.
  - cnt: LATW-bit countdown.
- Register 0 is never pending. Issues with iss_rd=0 or !iss_rd_we allocate nothing.
- Reset (synchronous, reset=1 at an edge):
  - All pend, var and cnt cleared.
  - pending_cnt=0, stall_count=0, wb_err=0.
  - While reset=1, stall=0 and issue_ok=0.
- "ready(r)" is true if any of the following holds:
  - !pend[r];
  - r==0;
  - BYPASS=1 and the entry is fixed with cnt==1;
  - BYPASS=1 and the entry is var with wb_valid && wb_reg==r.
- RAW: (iss_rs_use && !ready(iss_rs)) || (iss_rt_use && !ready(iss_rt)).
- WAW: iss_rd_we && iss_rd!=0 && pend[iss_rd]. Bypass is ignored for WAW; a pending destination always stalls.
- stall = iss_valid && (RAW || WAW) && !reset. flush does not mask stall.
- Accepted issue (issue_ok=1) with iss_rd_we, iss_rd!=0, at edge T:
  - Sets pend[iss_rd].
  - If iss_lat>0: var=0, cnt=iss_lat.
  - If iss_lat=0: var=1, cnt=0.
- Fixed entries, each edge:
  - cnt==1: clear pend.
  - Otherwise decrement cnt.
  - Net effect: an entry issued at edge T with latency L is pending during cycles T+1..T+L and clear from T+L+1.
- Variable entries: pend is cleared at the edge where wb_valid && wb_reg==r.
- Spurious writeback: wb_valid to a register that is not pending or not var, or wb_reg=0. The state is unchanged and wb_err=1 for the next cycle.
- flush=1 at an edge:
  - The current issue is dropped; issue_ok=0 already this cycle.
  - All fixed entries are cleared.
  - Var entries are kept, because memory and divider operations are not cancellable. A same-cycle wb still clears its entry.
- Simultaneous events: because of the WAW stall, an issue and the clearing of the same register cannot coincide. Issues to different registers, countdowns and wb are independent within one edge.
- pending_cnt: registered population count of pend after the update, equal to the number of set pend bits.
- stall_count: increments at each edge where stall=1; saturates at 2**PERFW-1.

Test Plan:
1. Load-use, BYPASS=1.
   - Stimulus: issue rd=5, lat=0 at T. Next cycle, issue rs=5 with use. wb_valid, wb_reg=5 at T+3.
   - Required: stall=1 in cycles T+1..T+2. stall=0 in T+3 (bypass) and issue_ok=1. pending_cnt goes 1 then 0.
2. Fixed latency, BYPASS=0.
   - Stimulus: issue rd=7, lat=3 at T; consumer of rt=7 waiting.
   - Required: stall=1 in cycles T+1..T+3, stall=0 at T+4. With BYPASS=1, stall=0 already at T+3.
3. WAW.
   - Stimulus: issue rd=9, lat=0. Then issue rd=9, lat=1 with no sources.
   - Required: stall=1 until the cycle after wb_reg=9. Bypass does not shorten this.
4. Flush.
   - Stimulus: pending rd=3 (lat=4) and rd=4 (var). Pulse flush.
   - Required: pend[3] cleared, pend[4] kept, pending_cnt=1. The issue presented in the flush cycle is not recorded.
5. Register 0 and spurious writeback.
   - Stimulus: issue rd=0, lat=0, followed by a consumer of rs=0. Separately, wb_reg=12 with 12 not pending.
   - Required: the consumer sees stall=0. wb_err pulses for exactly one cycle; pending_cnt is unchanged.
6. Reset mid-operation and counter saturation.
   - Stimulus: assert reset with 3 entries pending. Separately, hold a RAW stall for more than 2**PERFW cycles (PERFW=4 build).
   - Required: after reset, pending_cnt=0 and stall=0. stall_count stops at 15.
